// File: rtl/noise_gate_pkg.sv
// Shared types and constants for the noise gate: gate state encoding,
// gain/sample widths and the saturating magnitude helper.
package noise_gate_pkg;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } gate_state_t;

    localparam int          GAIN_W     = 9;
    localparam logic [8:0]  GAIN_UNITY = 9'd256;
    localparam int          SAMPLE_W   = 16;

    // -32768 has no positive counterpart in 16 bits, so it saturates to 32767
    function automatic logic [15:0] sat_abs(input logic [15:0] x);
        logic [15:0] mag;
        if (x == 16'h8000) begin
            mag = 16'h7FFF;
        end else if (x[15]) begin
            mag = 16'd0 - x;
        end else begin
            mag = x;
        end
        return mag;
    endfunction

endpackage

// File: rtl/gate_env_follower.sv
// One-pole envelope follower on the sample magnitude; exposes both the
// registered envelope and the value it will take on the current strobe.
module gate_env_follower
    import noise_gate_pkg::*;
#(
    parameter int ENV_SHIFT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    output logic [15:0]                env_next,
    output logic [15:0]                env
);

    logic [15:0]        env_r;
    logic [15:0]        mag_s;
    logic signed [16:0] diff_s;
    logic signed [16:0] step_s;
    logic signed [16:0] sum_s;
    logic               unused_s;

    // Envelope update; arithmetic shift keeps the result inside 0..32767
    always_comb begin
        mag_s    = sat_abs(in_sample);
        diff_s   = $signed({1'b0, mag_s}) - $signed({1'b0, env_r});
        step_s   = diff_s >>> ENV_SHIFT;
        sum_s    = $signed({1'b0, env_r}) + step_s;
        env_next = sum_s[15:0];
    end

    assign unused_s = sum_s[16];
    assign env      = env_r;

    // Envelope register advances only on qualified samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            env_r <= 16'd0;
        end else if (in_valid) begin
            env_r <= env_next;
        end else begin
            env_r <= env_r;
        end
    end

endmodule

// File: rtl/noise_gate.sv
// Envelope-driven noise gate: hysteresis FSM with hold timer, linear gain
// ramps and a one-clock gain multiplier on the sample path.
module noise_gate
    import noise_gate_pkg::*;
#(
    parameter logic [15:0] OPEN_THRESH  = 16'd512,
    parameter logic [15:0] CLOSE_THRESH = 16'd256,
    parameter int          ENV_SHIFT    = 4,
    parameter int          HOLD_SAMPLES = 480,
    parameter logic [8:0]  ATTACK_STEP  = 9'd32,
    parameter logic [8:0]  RELEASE_STEP = 9'd1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    output logic                       out_valid,
    output logic signed [SAMPLE_W-1:0] out_sample,
    output logic                       gate_open,
    output logic [15:0]                env_level
);

    localparam int                HOLD_W    = $clog2(HOLD_SAMPLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES - 1);

    gate_state_t                state_r;
    gate_state_t                state_s;
    logic [GAIN_W-1:0]          gain_r;
    logic [GAIN_W-1:0]          gain_s;
    logic [HOLD_W-1:0]          hold_r;
    logic [HOLD_W-1:0]          hold_s;
    logic                       gate_open_r;
    logic                       out_valid_r;
    logic signed [SAMPLE_W-1:0] out_sample_r;

    logic [15:0]                env_next_s;
    logic [15:0]                env_s;
    logic                       above_open_s;
    logic                       below_close_s;
    logic [GAIN_W:0]            attack_sum_s;
    logic signed [24:0]         prod_s;
    logic signed [SAMPLE_W-1:0] gated_s;
    logic                       unused_s;

    gate_env_follower #(
        .ENV_SHIFT (ENV_SHIFT)
    ) u_env (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .env_next  (env_next_s),
        .env       (env_s)
    );

    // Gain multiply uses the gain held before this sample's FSM update
    always_comb begin
        prod_s  = $signed({{9{in_sample[15]}}, in_sample}) * $signed({16'd0, gain_r});
        gated_s = prod_s[23:8];
    end

    assign unused_s = ^{prod_s[24], prod_s[7:0]};

    // Next-state, gain and hold-counter logic, evaluated against env_next
    always_comb begin
        state_s       = state_r;
        gain_s        = gain_r;
        hold_s        = hold_r;
        above_open_s  = (env_next_s >= OPEN_THRESH);
        below_close_s = (env_next_s < CLOSE_THRESH);
        attack_sum_s  = {1'b0, gain_r} + {1'b0, ATTACK_STEP};

        if (!in_valid) begin
            state_s = state_r;
        end else if (!enable) begin
            state_s = CLOSED;
            gain_s  = 9'd0;
            hold_s  = '0;
        end else begin
            case (state_r)
                CLOSED: begin
                    gain_s = 9'd0;
                    if (above_open_s) begin
                        state_s = ATTACK;
                    end else begin
                        state_s = CLOSED;
                    end
                end
                ATTACK: begin
                    if (below_close_s) begin
                        state_s = RELEASE;
                    end else if (attack_sum_s >= {1'b0, GAIN_UNITY}) begin
                        gain_s  = GAIN_UNITY;
                        state_s = OPEN;
                    end else begin
                        gain_s  = attack_sum_s[GAIN_W-1:0];
                    end
                end
                OPEN: begin
                    gain_s = GAIN_UNITY;
                    if (below_close_s) begin
                        state_s = HOLD;
                        hold_s  = HOLD_LOAD;
                    end else begin
                        state_s = OPEN;
                    end
                end
                HOLD: begin
                    gain_s = GAIN_UNITY;
                    if (above_open_s) begin
                        state_s = OPEN;
                    end else if (hold_r == '0) begin
                        state_s = RELEASE;
                    end else begin
                        hold_s  = hold_r - HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    if (above_open_s) begin
                        state_s = ATTACK;
                    end else if (gain_r <= RELEASE_STEP) begin
                        gain_s  = 9'd0;
                        state_s = CLOSED;
                    end else begin
                        gain_s  = gain_r - RELEASE_STEP;
                    end
                end
                default: begin
                    state_s = CLOSED;
                    gain_s  = 9'd0;
                    hold_s  = '0;
                end
            endcase
        end
    end

    // State, gain, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= CLOSED;
            gain_r       <= 9'd0;
            hold_r       <= '0;
            gate_open_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            out_sample_r <= 16'sd0;
        end else begin
            state_r     <= state_s;
            gain_r      <= gain_s;
            hold_r      <= hold_s;
            gate_open_r <= (state_s != CLOSED);
            out_valid_r <= in_valid;
            if (in_valid) begin
                out_sample_r <= enable ? gated_s : in_sample;
            end else begin
                out_sample_r <= out_sample_r;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_sample = out_sample_r;
    assign gate_open  = gate_open_r;
    assign env_level  = env_s;

endmodule

// File: tb/tb_noise_gate.sv
// Randomized self-checking bench for noise_gate against an arithmetic
// reference model of the gate rules.
module tb_noise_gate;

    logic               clk;
    logic               rst;
    logic               enable;
    logic               in_valid;
    logic signed [15:0] in_sample;
    logic               out_valid;
    logic signed [15:0] out_sample;
    logic               gate_open;
    logic [15:0]        env_level;

    int checks;
    int errors;

    // reference model state
    localparam int M_CLOSED = 0, M_ATTACK = 1, M_OPEN = 2, M_HOLD = 3, M_RELEASE = 4;
    int m_env, m_gain, m_state, m_cnt;
    int m_out;
    bit m_open;

    noise_gate dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .gate_open  (gate_open),
        .env_level  (env_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_env = 0; m_gain = 0; m_state = M_CLOSED; m_cnt = 0; m_out = 0; m_open = 0;
    endtask

    task automatic model_step(input int x, input bit en);
        int a, d, sh, e;
        a  = (x == -32768) ? 32767 : ((x < 0) ? -x : x);
        d  = a - m_env;
        sh = (d >= 0) ? d / 16 : -((-d + 15) / 16);
        e  = m_env + sh;
        m_out = en ? ((x * m_gain) >>> 8) : x;
        if (!en) begin
            m_state = M_CLOSED; m_gain = 0; m_cnt = 0;
        end else if (m_state == M_CLOSED) begin
            if (e >= 512) m_state = M_ATTACK;
        end else if (m_state == M_ATTACK) begin
            if (e < 256) m_state = M_RELEASE;
            else begin
                m_gain = (m_gain + 32 > 256) ? 256 : m_gain + 32;
                if (m_gain == 256) m_state = M_OPEN;
            end
        end else if (m_state == M_OPEN) begin
            if (e < 256) begin m_state = M_HOLD; m_cnt = 479; end
        end else if (m_state == M_HOLD) begin
            if (e >= 512) m_state = M_OPEN;
            else if (m_cnt == 0) m_state = M_RELEASE;
            else m_cnt = m_cnt - 1;
        end else begin
            if (e >= 512) m_state = M_ATTACK;
            else begin
                m_gain = (m_gain - 1 < 0) ? 0 : m_gain - 1;
                if (m_gain == 0) m_state = M_CLOSED;
            end
        end
        m_env  = e;
        m_open = (m_state != M_CLOSED);
    endtask

    // drive one strobe and advance the model; outputs settle at posedge+1
    task automatic strobe(input int x);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = 16'(x);
        model_step(x, enable);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) strobe(int'($urandom_range(8000, 0)));
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sample !== 16'sd0 || gate_open !== 1'b0 || env_level !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b out=%0d open=%b env=%0d required 0 0 0 0",
                     out_valid, out_sample, gate_open, env_level);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            strobe(0);
            checks++;
            if (out_valid !== 1'b1 || out_sample !== 16'sd0 || gate_open !== 1'b0 || env_level !== 16'd0) begin
                errors++;
                $display("FAIL silence_%0d: valid=%b out=%0d open=%b env=%0d required 1 0 0 0",
                         i, out_valid, out_sample, gate_open, env_level);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL silence_gap_%0d: out_valid=%b required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_open_attack();
        int env_req [3];
        env_req = '{250, 484, 703};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            strobe(4000);
            checks++;
            if (out_sample !== 16'(m_out) || gate_open !== m_open || env_level !== 16'(m_env)) begin
                errors++;
                $display("FAIL attack_%0d: out=%0d open=%b env=%0d required %0d %b %0d",
                         i, out_sample, gate_open, env_level, m_out, m_open, m_env);
            end
            if (i < 3) begin
                checks++;
                if (env_level !== 16'(env_req[i]) || gate_open !== (i == 2)) begin
                    errors++;
                    $display("FAIL env_seq_%0d: env=%0d open=%b required %0d %b",
                             i, env_level, gate_open, env_req[i], (i == 2));
                end
            end
            if (i >= 4 && i <= 11) begin
                checks++;
                if (out_sample !== 16'(500 * (i - 3))) begin
                    errors++;
                    $display("FAIL ramp_%0d: out=%0d required %0d", i, out_sample, 500 * (i - 3));
                end
            end
        end
        checks++;
        if (out_sample !== 16'sd4000) begin
            errors++;
            $display("FAIL unity_4000: out=%0d required 4000", out_sample);
        end
    endtask

    task automatic test_hold_release();
        int n;
        int n100;
        n = 0;
        n100 = 0;
        while (m_state != M_CLOSED && n < 2000) begin
            strobe(100);
            n++;
            if (out_sample === 16'sd100) n100++;
            checks++;
            if (out_sample !== 16'(m_out) || gate_open !== m_open || env_level !== 16'(m_env)) begin
                errors++;
                $display("FAIL hold_rel_%0d: out=%0d open=%b env=%0d required %0d %b %0d",
                         n, out_sample, gate_open, env_level, m_out, m_open, m_env);
            end
        end
        checks++;
        if (n >= 2000 || gate_open !== 1'b0 || out_sample !== 16'sd0 || n100 < 480) begin
            errors++;
            $display("FAIL closed_after_release: strobes=%0d open=%b out=%0d n100=%0d required closed 0 0 >=480",
                     n, gate_open, out_sample, n100);
        end
    endtask

    task automatic test_hysteresis();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            strobe(300);
            checks++;
            if (out_sample !== 16'sd0 || gate_open !== 1'b0 || gate_open !== m_open) begin
                errors++;
                $display("FAIL hyst_closed_%0d: out=%0d open=%b required 0 0", i, out_sample, gate_open);
            end
        end
        for (int i = 0; i < 20; i++) strobe(4000);
        for (int i = 0; i < 120; i++) begin
            strobe(300);
            checks++;
            if (out_sample !== 16'sd300 || gate_open !== 1'b1 || env_level !== 16'(m_env)) begin
                errors++;
                $display("FAIL hyst_open_%0d: out=%0d open=%b env=%0d required 300 1 %0d",
                         i, out_sample, gate_open, env_level, m_env);
            end
        end
    endtask

    task automatic test_retrigger();
        int n;
        do_reset();
        for (int i = 0; i < 15; i++) strobe(4000);
        n = 0;
        while (!(m_state == M_RELEASE && m_gain == 128) && n < 2000) begin
            strobe(0);
            n++;
        end
        checks++;
        if (n >= 2000 || gate_open !== 1'b1) begin
            errors++;
            $display("FAIL reach_release_128: strobes=%0d open=%b required <2000 1", n, gate_open);
        end
        for (int i = 0; i < 20; i++) begin
            strobe(4000);
            checks++;
            if (out_sample !== 16'(m_out) || gate_open !== 1'b1 || gate_open !== m_open) begin
                errors++;
                $display("FAIL retrigger_%0d: out=%0d open=%b required %0d 1", i, out_sample, gate_open, m_out);
            end
        end
        checks++;
        if (out_sample !== 16'sd4000) begin
            errors++;
            $display("FAIL retrigger_unity: out=%0d required 4000", out_sample);
        end
        // async reset while ramping up
        do_reset();
        for (int i = 0; i < 5; i++) strobe(4000);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_sample !== 16'sd0 || gate_open !== 1'b0 || env_level !== 16'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_attack: out=%0d open=%b env=%0d valid=%b required 0 0 0 0",
                     out_sample, gate_open, env_level, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_bypass();
        int vals [4];
        vals = '{-32768, 32767, 1, -5};
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe(vals[i]);
            checks++;
            if (out_valid !== 1'b1 || out_sample !== 16'(vals[i]) || out_sample !== 16'(m_out) || gate_open !== 1'b0) begin
                errors++;
                $display("FAIL bypass_%0d: valid=%b out=%0d open=%b required 1 %0d 0",
                         i, out_valid, out_sample, gate_open, vals[i]);
            end
            for (int g = 0; g < 5; g++) begin
                @(posedge clk);
                #1;
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_%0d_%0d: out_valid=%b required 0", i, g, out_valid);
                end
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 15; i++) strobe(4000);
        strobe(-32768);
        checks++;
        if (out_sample !== -16'sd32768 || gate_open !== 1'b1) begin
            errors++;
            $display("FAIL unity_min: out=%0d open=%b required -32768 1", out_sample, gate_open);
        end
    endtask

    task automatic test_random();
        int seg_len, cls, amp, x;
        int n;
        n = 0;
        do_reset();
        while (n < 2500) begin
            seg_len = int'($urandom_range(300, 1));
            cls     = int'($urandom_range(3, 0));
            enable  = ($urandom_range(15, 0) != 0);
            for (int k = 0; k < seg_len && n < 2500; k++) begin
                case (cls)
                    0:       amp = int'($urandom_range(50, 0));
                    1:       amp = int'($urandom_range(450, 200));
                    2:       amp = int'($urandom_range(3000, 500));
                    default: amp = int'($urandom_range(32768, 3000));
                endcase
                x = ($urandom_range(1, 0) == 1) ? -amp : ((amp > 32767) ? 32767 : amp);
                strobe(x);
                n++;
                checks++;
                if (out_valid !== 1'b1 || out_sample !== 16'(m_out) || gate_open !== m_open || env_level !== 16'(m_env)) begin
                    errors++;
                    $display("FAIL random_%0d: in=%0d valid=%b out=%0d open=%b env=%0d required 1 %0d %b %0d",
                             n, x, out_valid, out_sample, gate_open, env_level, m_out, m_open, m_env);
                end
                if ($urandom_range(7, 0) == 0) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL random_gap_%0d: out_valid=%b required 0", n, out_valid);
                    end
                end
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_sample = 16'sd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_open_attack();
        test_hold_release();
        test_hysteresis();
        test_retrigger();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
